arr_4x4: RTL and testbench
==========================

# arr_4x4

Weight-stationary 4x4 systolic multiply-accumulate array with per-PE fault injection, the compute core of the NPU datapath.
- Weights are shifted in from the top and frozen with `hold`.
- Activations stream in from the left, skewed one cycle per row.
- Partial sums flow downward and leave the bottom as four 24-bit column results.

## Interface
Parameters: none. Widths are fixed by package constants.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Err_mac` input 16: MAC fault-inject mask. Bit k = row*4+col; row 0 is the top row, col 0 is the left column.
- `Err_mult` input 16: multiplier fault-inject mask, same bit indexing as `Err_mac`.
- `w1_in..w4_in` input 8 each: unsigned weights entering the top of columns 0..3.
- `a1_in..a4_in` input 8 each: unsigned activations entering the left of rows 0..3.
- `w1_out..w4_out` output 8 each: weight registers of the bottom-row PEs, columns 0..3.
- `a1_out..a4_out` output 8 each: activation registers of the right-column PEs, rows 0..3.
- `c1_out..c4_out` output 24 each: psum registers of the bottom-row PEs, columns 0..3.
- `hold` input 1: 1 freezes all weight registers.

## Operation
Each PE(r,c) has three registers: `w_reg` (8 bits), `a_reg` (8 bits) and `p_reg` (24 bits).

Inputs to PE(r,c):
- `w_src`: `w*_in` for r=0, otherwise `w_reg` of PE(r-1,c).
- `a_src`: `a*_in` for c=0, otherwise `a_reg` of PE(r,c-1).
- `p_src`: 0 for r=0, otherwise `p_reg` of PE(r-1,c).

Per rising edge, when `rst`=0:
- If `hold`=0: `w_reg` <= `w_src`. If `hold`=1, `w_reg` keeps its value.
- `a_reg` <= `a_src`, every cycle, independent of `hold`.
- `prod` = `a_src` * `w_reg`: unsigned, 16 bits. It is forced to 0 when `Err_mult[k]`=1.
- `sum` = `p_src` + zero-extend(`prod`), modulo 2^24.
- `p_reg` <= `sum`, or `sum` XOR 1 (LSB flipped) when `Err_mac[k]`=1.

Fault rules:
- Both fault bits set on one PE: product forced to 0, then the LSB is flipped.
- The fault masks are sampled combinationally each cycle and may change at any time.

Arithmetic: all arithmetic is unsigned. A fault-free result is at most 4*255*255, so it fits in 24 bits.

Reset: when `rst`=1 at an edge, every `w_reg`, `a_reg` and `p_reg` is cleared to 0. Reset overrides `hold`. All outputs are therefore 0 after reset. Reset mid-stream discards all weights and partial sums.

## Timing
Register delays:
- A weight presented at the top reaches row r after r+1 non-held edges.
- Loading a full column takes 4 edges with `hold`=0; the first value loaded ends in row 3.
- `w*_out` equals `w*_in` delayed 4 unheld edges.
- `a*_out` equals `a*_in` delayed 4 edges.

Streaming rules:
- Activation vectors must be skewed: row r is driven r cycles after row 0.
- Let row 0 be driven before edge t.
- PE(r,c) accumulates at edge t+r+c.
- `c(c+1)_out` holds the full column dot-product sum_r a_r*w(r,c) after edge t+3+c.
- The array accepts one new skewed vector per cycle, fully pipelined.

`hold` is level-sensitive and takes effect at the same edge it is sampled.

## Structure
- Package `arr_pkg` holds three constants: `DATA_W`=8, `ACC_W`=24 and `ARR_N`=4.
- Sub-module `arr_pe` contains the three registers, the multiply/add and the two fault controls, with ports clk, rst, hold, err_mac, err_mult, w_in/w_out, a_in/a_out, p_in/p_out.
- `arr_4x4` is a 4x4 generate grid of `arr_pe` plus output wiring.

## Test plan
- **Reset:** hold `rst`=1 for 2 edges with nonzero inputs, release, keep inputs 0 -> every output is 0.
- **Load and freeze:** drive `w_in`=(1,2,3,4) for 4 edges with `hold`=0, then set `hold`=1.
  - `w_out`=(1,2,3,4).
  - Change `w_in` to 9 -> `w_out` is unchanged.
- **Dot product:** with the weights above, pulse a 1 skewed through rows 0..3 (row r at cycle r), fault masks 0.
  - `c1_out`..`c4_out` = 4, 8, 12, 16 after edges t+3..t+6.
  - All outputs return to 0 afterwards.
- **Multiplier fault:** repeat the dot-product stimulus with `Err_mult`=0x0001 -> `c1_out`=3; other columns are unchanged.
- **MAC fault:** repeat the dot-product stimulus with `Err_mac`=0x0010 (PE row1,col0) -> `c1_out`=5.
- **Activation pass-through and max value:** drive `a1_in` with the sequence 8,7,6 -> `a1_out` shows 8,7,6 starting 4 edges later.
  - With all weights 255 and activations 255 -> `c_out`=260100 (0x03F804).

Source files
------------

// File: rtl/arr_pkg.sv
// Shared width and size constants for the 4x4 weight-stationary MAC array.
package arr_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int ARR_N  = 4;
endpackage

// File: rtl/arr_if.sv
// Bundles the array's data, control and fault-mask signals.
// The master side drives weights, activations, hold and masks; the slave side is the array.
interface arr_if;
    import arr_pkg::*;

    logic [ARR_N*ARR_N-1:0] Err_mac;
    logic [ARR_N*ARR_N-1:0] Err_mult;
    logic                   hold;

    logic [DATA_W-1:0] w1_in, w2_in, w3_in, w4_in;
    logic [DATA_W-1:0] a1_in, a2_in, a3_in, a4_in;
    logic [DATA_W-1:0] w1_out, w2_out, w3_out, w4_out;
    logic [DATA_W-1:0] a1_out, a2_out, a3_out, a4_out;
    logic [ACC_W-1:0]  c1_out, c2_out, c3_out, c4_out;

    modport master (
        output Err_mac, Err_mult, hold,
        output w1_in, w2_in, w3_in, w4_in,
        output a1_in, a2_in, a3_in, a4_in,
        input  w1_out, w2_out, w3_out, w4_out,
        input  a1_out, a2_out, a3_out, a4_out,
        input  c1_out, c2_out, c3_out, c4_out
    );

    modport slave (
        input  Err_mac, Err_mult, hold,
        input  w1_in, w2_in, w3_in, w4_in,
        input  a1_in, a2_in, a3_in, a4_in,
        output w1_out, w2_out, w3_out, w4_out,
        output a1_out, a2_out, a3_out, a4_out,
        output c1_out, c2_out, c3_out, c4_out
    );
endinterface

// File: rtl/arr_pe.sv
// One processing element: holds a weight, forwards the activation right and
// accumulates a_in * w_reg into the partial sum flowing down, with fault injection.
module arr_pe
    import arr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              err_mac,
    input  logic              err_mult,
    input  logic [DATA_W-1:0] w_in,
    output logic [DATA_W-1:0] w_out,
    input  logic [DATA_W-1:0] a_in,
    output logic [DATA_W-1:0] a_out,
    input  logic [ACC_W-1:0]  p_in,
    output logic [ACC_W-1:0]  p_out
);
    logic [DATA_W-1:0]   w_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [ACC_W-1:0]    p_reg;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    sum;

    // The product uses the weight already resident here, not the one arriving this edge.
    always_comb begin
        prod = '0;
        if (!err_mult) begin
            prod = a_in * w_reg;
        end
        sum = p_in + {{(ACC_W-2*DATA_W){1'b0}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_reg <= '0;
            a_reg <= '0;
            p_reg <= '0;
        end else begin
            if (!hold) begin
                w_reg <= w_in;
            end
            a_reg <= a_in;
            p_reg <= sum ^ {{(ACC_W-1){1'b0}}, err_mac};
        end
    end

    assign w_out = w_reg;
    assign a_out = a_reg;
    assign p_out = p_reg;
endmodule

// File: rtl/arr_4x4.sv
// 4x4 systolic grid of arr_pe: weights shift down, activations shift right,
// partial sums leave the bottom row as four column results.
module arr_4x4
    import arr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    arr_if.slave bus
);
    // Index [r][c] is the input of PE(r,c); the extra row/column carries the edge outputs.
    logic [DATA_W-1:0] w_bus [ARR_N+1][ARR_N];
    logic [DATA_W-1:0] a_bus [ARR_N][ARR_N+1];
    logic [ACC_W-1:0]  p_bus [ARR_N+1][ARR_N];

    assign w_bus[0][0] = bus.w1_in;
    assign w_bus[0][1] = bus.w2_in;
    assign w_bus[0][2] = bus.w3_in;
    assign w_bus[0][3] = bus.w4_in;

    assign a_bus[0][0] = bus.a1_in;
    assign a_bus[1][0] = bus.a2_in;
    assign a_bus[2][0] = bus.a3_in;
    assign a_bus[3][0] = bus.a4_in;

    genvar r, c;
    generate
        for (c = 0; c < ARR_N; c++) begin : g_top
            assign p_bus[0][c] = '0;
        end
        for (r = 0; r < ARR_N; r++) begin : g_row
            for (c = 0; c < ARR_N; c++) begin : g_col
                arr_pe u_pe (
                    .clk      (clk),
                    .rst      (rst),
                    .hold     (bus.hold),
                    .err_mac  (bus.Err_mac[r*ARR_N+c]),
                    .err_mult (bus.Err_mult[r*ARR_N+c]),
                    .w_in     (w_bus[r][c]),
                    .w_out    (w_bus[r+1][c]),
                    .a_in     (a_bus[r][c]),
                    .a_out    (a_bus[r][c+1]),
                    .p_in     (p_bus[r][c]),
                    .p_out    (p_bus[r+1][c])
                );
            end
        end
    endgenerate

    assign bus.w1_out = w_bus[ARR_N][0];
    assign bus.w2_out = w_bus[ARR_N][1];
    assign bus.w3_out = w_bus[ARR_N][2];
    assign bus.w4_out = w_bus[ARR_N][3];

    assign bus.a1_out = a_bus[0][ARR_N];
    assign bus.a2_out = a_bus[1][ARR_N];
    assign bus.a3_out = a_bus[2][ARR_N];
    assign bus.a4_out = a_bus[3][ARR_N];

    assign bus.c1_out = p_bus[ARR_N][0];
    assign bus.c2_out = p_bus[ARR_N][1];
    assign bus.c3_out = p_bus[ARR_N][2];
    assign bus.c4_out = p_bus[ARR_N][3];
endmodule

// File: tb/tb_arr_4x4.sv
// Self-checking bench for arr_4x4: a cycle model feeds a scoreboard queue that is
// compared after every edge, plus directed checks of the hand-computed results.
module tb_arr_4x4;
    import arr_pkg::*;

    typedef struct packed {
        logic [3:0][7:0]  w;
        logic [3:0][7:0]  a;
        logic [3:0][23:0] c;
    } outs_t;

    logic clk = 1'b0;
    logic rst;

    arr_if bus();

    arr_4x4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    outs_t sb_q[$];

    logic [7:0]  w_in_v [4];
    logic [7:0]  a_in_v [4];
    logic        hold_v;
    logic [15:0] mac_v;
    logic [15:0] mult_v;

    logic [7:0]  mw [4][4];
    logic [7:0]  ma [4][4];
    logic [23:0] mp [4][4];

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic applyStimulus();
        bus.w1_in    = w_in_v[0];
        bus.w2_in    = w_in_v[1];
        bus.w3_in    = w_in_v[2];
        bus.w4_in    = w_in_v[3];
        bus.a1_in    = a_in_v[0];
        bus.a2_in    = a_in_v[1];
        bus.a3_in    = a_in_v[2];
        bus.a4_in    = a_in_v[3];
        bus.hold     = hold_v;
        bus.Err_mac  = mac_v;
        bus.Err_mult = mult_v;
    endtask

    function automatic logic [23:0] get_c(input int i);
        case (i)
            0:       return bus.c1_out;
            1:       return bus.c2_out;
            2:       return bus.c3_out;
            default: return bus.c4_out;
        endcase
    endfunction

    function automatic logic [7:0] get_w(input int i);
        case (i)
            0:       return bus.w1_out;
            1:       return bus.w2_out;
            2:       return bus.w3_out;
            default: return bus.w4_out;
        endcase
    endfunction

    function automatic logic [7:0] get_a(input int i);
        case (i)
            0:       return bus.a1_out;
            1:       return bus.a2_out;
            2:       return bus.a3_out;
            default: return bus.a4_out;
        endcase
    endfunction

    // Reference model of one rising edge, built from the array's behavioural description.
    task automatic modelEdge();
        logic [7:0]  nw [4][4];
        logic [7:0]  na [4][4];
        logic [23:0] np [4][4];
        logic [7:0]  ws, as;
        logic [23:0] ps;
        logic [15:0] pr;
        outs_t       e;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ws = (r == 0) ? w_in_v[c] : mw[r-1][c];
                as = (c == 0) ? a_in_v[r] : ma[r][c-1];
                ps = (r == 0) ? 24'd0 : mp[r-1][c];
                pr = 16'(as) * 16'(mw[r][c]);
                if (mult_v[r*4+c]) pr = 16'd0;
                np[r][c] = ps + {8'd0, pr};
                if (mac_v[r*4+c]) np[r][c] = np[r][c] ^ 24'd1;
                nw[r][c] = hold_v ? mw[r][c] : ws;
                na[r][c] = as;
                if (rst) begin
                    nw[r][c] = 8'd0;
                    na[r][c] = 8'd0;
                    np[r][c] = 24'd0;
                end
            end
        end
        mw = nw;
        ma = na;
        mp = np;
        for (int i = 0; i < 4; i++) begin
            e.w[i] = mw[3][i];
            e.a[i] = ma[i][3];
            e.c[i] = mp[3][i];
        end
        sb_q.push_back(e);
    endtask

    task automatic stepCycle();
        outs_t e;
        applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sb_w%0d_out", i+1), get_w(i), e.w[i]);
            checkOutput($sformatf("sb_a%0d_out", i+1), get_a(i), e.a[i]);
            checkOutput($sformatf("sb_c%0d_out", i+1), get_c(i), e.c[i]);
        end
    endtask

    task automatic clearActs();
        for (int i = 0; i < 4; i++) a_in_v[i] = 8'd0;
    endtask

    // Skewed single-value pulse down rows 0..3; column j completes after edge t+3+j.
    task automatic runPulse(input string name, input logic [7:0] val,
                            input logic [23:0] e0, input logic [23:0] e1,
                            input logic [23:0] e2, input logic [23:0] e3);
        logic [23:0] exp_c [4];
        exp_c[0] = e0;
        exp_c[1] = e1;
        exp_c[2] = e2;
        exp_c[3] = e3;
        for (int k = 0; k < 7; k++) begin
            clearActs();
            if (k < 4) a_in_v[k] = val;
            stepCycle();
            if (k >= 3) checkOutput($sformatf("%s_c%0d", name, k-2), get_c(k-3), exp_c[k-3]);
        end
    endtask

    task automatic flush(input int n);
        clearActs();
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        logic [7:0] seq [3];
        seq[0] = 8'd8;
        seq[1] = 8'd7;
        seq[2] = 8'd6;

        // Reset with nonzero inputs, then release with everything at zero.
        rst    = 1'b1;
        hold_v = 1'b0;
        mac_v  = 16'hFFFF;
        mult_v = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            w_in_v[i] = 8'd5;
            a_in_v[i] = 8'd7;
        end
        stepCycle();
        stepCycle();
        rst    = 1'b0;
        mac_v  = 16'h0;
        mult_v = 16'h0;
        for (int i = 0; i < 4; i++) w_in_v[i] = 8'd0;
        clearActs();
        stepCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst_c%0d", i+1), get_c(i), 24'd0);
            checkOutput($sformatf("rst_w%0d", i+1), get_w(i), 8'd0);
            checkOutput($sformatf("rst_a%0d", i+1), get_a(i), 8'd0);
        end

        // Load weights 1..4 across the columns, then freeze them.
        for (int i = 0; i < 4; i++) w_in_v[i] = 8'(i + 1);
        for (int k = 0; k < 4; k++) stepCycle();
        hold_v = 1'b1;
        for (int i = 0; i < 4; i++) checkOutput($sformatf("load_w%0d", i+1), get_w(i), 32'(i + 1));
        for (int i = 0; i < 4; i++) w_in_v[i] = 8'd9;
        stepCycle();
        stepCycle();
        for (int i = 0; i < 4; i++) checkOutput($sformatf("hold_w%0d", i+1), get_w(i), 32'(i + 1));

        runPulse("dot", 8'd1, 24'd4, 24'd8, 24'd12, 24'd16);
        flush(6);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("drain_c%0d", i+1), get_c(i), 24'd0);

        mult_v = 16'h0001;
        runPulse("mult", 8'd1, 24'd3, 24'd8, 24'd12, 24'd16);
        mult_v = 16'h0;
        flush(6);

        mac_v = 16'h0010;
        runPulse("mac", 8'd1, 24'd5, 24'd8, 24'd12, 24'd16);
        mac_v = 16'h0;
        flush(6);

        // Activation pass-through on row 0.
        for (int k = 0; k < 8; k++) begin
            clearActs();
            if (k < 3) a_in_v[0] = seq[k];
            stepCycle();
            if (k >= 3 && k < 6) checkOutput($sformatf("apass_%0d", k-3), get_a(0), 32'(seq[k-3]));
        end
        flush(6);

        // Full-scale weights and activations.
        hold_v = 1'b0;
        for (int i = 0; i < 4; i++) w_in_v[i] = 8'd255;
        for (int k = 0; k < 4; k++) stepCycle();
        hold_v = 1'b1;
        runPulse("max", 8'd255, 24'd260100, 24'd260100, 24'd260100, 24'd260100);
        flush(6);

        // Random traffic with sparse faults, hold toggling and one mid-stream reset.
        for (int k = 0; k < 48; k++) begin
            rst    = (k == 24);
            hold_v = 1'($urandom_range(0, 1));
            mac_v  = 16'($urandom & $urandom & $urandom);
            mult_v = 16'($urandom & $urandom & $urandom);
            for (int i = 0; i < 4; i++) begin
                w_in_v[i] = 8'($urandom);
                a_in_v[i] = 8'($urandom);
            end
            stepCycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
